// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state type, port IDs and sizes for dmem_arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int MEM_BYTES_DEF = 64;
  localparam int DWORD_BYTES   = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last_grant register
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_id_o = PORT_A;
    if (a_valid_i && b_valid_i) begin
      grant_id_o = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (b_valid_i) begin
      grant_id_o = PORT_B;
    end
  end

  assign grant_valid_o = en_i && (a_valid_i || b_valid_i);

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_valid_o) last_grant_d = grant_id_o;
  end

  // Reset to B so that port A wins the first tie.
  always_ff @(posedge clock_i) begin
    if (!reset_i) last_grant_q <= PORT_B;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, 3-cycle access FSM
// Define DMEM_ARB_BOUNDS_CHECK_EN to reject accesses with addr > MEM_BYTES-8.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              a_rsp_err,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              b_rsp_err,
  output logic [ADDR_W-1:0] Memory_Address,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST_OK_ADDR = ADDR_W'(MEM_BYTES - DWORD_BYTES);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rsp_data_q, a_rsp_data_d, b_rsp_data_q, b_rsp_data_d;
  logic              a_rsp_err_q, a_rsp_err_d, b_rsp_err_q, b_rsp_err_d;

  logic              grant_valid, grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] acc_data;

  rr_arbiter2 u_rr (
    .clock_i       (clock),
    .reset_i       (reset),
    .en_i          (reset && (state_q == IDLE)),
    .a_valid_i     (a_req_valid),
    .b_valid_i     (b_req_valid),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign sel_we    = (grant_id == PORT_B) ? b_req_we    : a_req_we;
  assign sel_addr  = (grant_id == PORT_B) ? b_req_addr  : a_req_addr;
  assign sel_wdata = (grant_id == PORT_B) ? b_req_wdata : a_req_wdata;

  // Stores and rejected accesses report zero data.
  assign acc_data = (we_q || oob_q) ? '0 : Read_Data;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    oob_d        = oob_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_rsp_data_d = a_rsp_data_q;
    a_rsp_err_d  = a_rsp_err_q;
    b_rsp_data_d = b_rsp_data_q;
    b_rsp_err_d  = b_rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          port_d  = grant_id;
          we_d    = sel_we;
          oob_d   = BOUNDS_EN && (sel_addr > LAST_OK_ADDR);
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (port_q == PORT_A) begin
          a_rsp_data_d = acc_data;
          a_rsp_err_d  = oob_q;
        end else begin
          b_rsp_data_d = acc_data;
          b_rsp_err_d  = oob_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_A;
      we_q         <= 1'b0;
      oob_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_rsp_data_q <= '0;
      a_rsp_err_q  <= 1'b0;
      b_rsp_data_q <= '0;
      b_rsp_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      oob_q        <= oob_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_rsp_data_q <= a_rsp_data_d;
      a_rsp_err_q  <= a_rsp_err_d;
      b_rsp_data_q <= b_rsp_data_d;
      b_rsp_err_q  <= b_rsp_err_d;
    end
  end

  assign a_req_ready    = grant_valid && (grant_id == PORT_A);
  assign b_req_ready    = grant_valid && (grant_id == PORT_B);
  assign a_rsp_valid    = (state_q == RESP) && (port_q == PORT_A);
  assign b_rsp_valid    = (state_q == RESP) && (port_q == PORT_B);
  assign a_rsp_data     = a_rsp_data_q;
  assign a_rsp_err      = a_rsp_err_q;
  assign b_rsp_data     = b_rsp_data_q;
  assign b_rsp_err      = b_rsp_err_q;
  assign Memory_Address = addr_q;
  assign Write_Data     = wdata_q;
  assign MemWrite       = (state_q == ACCESS) &&  we_q && !oob_q;
  assign MemRead        = (state_q == ACCESS) && !we_q && !oob_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter with a transaction-level reference model
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam int MB = 64;

  logic        clock, reset;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_data;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_data;
  logic [63:0] Memory_Address, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MB)) dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
    .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
    .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
    .Memory_Address(Memory_Address), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory attached to the DUT, little-endian, wraps at MB.
  logic [7:0] mem [MB];
  bit         mem_init = 1'b0;

  always_comb begin
    Read_Data = '0;
    for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[(int'(Memory_Address[5:0]) + i) % MB];
  end

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
      mem_init <= 1'b1;
    end else if (MemWrite === 1'b1) begin
      for (int i = 0; i < 8; i++) mem[(int'(Memory_Address[5:0]) + i) % MB] <= Write_Data[8*i +: 8];
    end
  end

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
  } exp_t;

  function automatic req_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk(1'($urandom_range(0, 1)), 64'($urandom_range(0, MB - 1)), {$urandom, $urandom});
  endfunction

  // Driver: requests come from per-port queues (written only by the main sequence), or randomly.
  req_t qa_req[$], qb_req[$];
  int   ia = 0, ib = 0, seen_a = 0, seen_b = 0;
  bit   rand_en = 1'b0;
  int   hs_a_cnt = 0, hs_b_cnt = 0;

  initial begin
    req_t r;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    forever begin
      @(posedge clock); #1;
      if (hs_a_cnt != seen_a) begin seen_a = hs_a_cnt; a_req_valid = 1'b0; end
      if (!a_req_valid) begin
        r = rand_req();
        if (ia < qa_req.size()) begin r = qa_req[ia]; ia++; a_req_valid = 1'b1; end
        else if (rand_en && $urandom_range(0, 1) == 1) a_req_valid = 1'b1;
        {a_req_we, a_req_addr, a_req_wdata} = r;
      end
      if (hs_b_cnt != seen_b) begin seen_b = hs_b_cnt; b_req_valid = 1'b0; end
      if (!b_req_valid) begin
        r = rand_req();
        if (ib < qb_req.size()) begin r = qb_req[ib]; ib++; b_req_valid = 1'b1; end
        else if (rand_en && $urandom_range(0, 1) == 1) b_req_valid = 1'b1;
        {b_req_we, b_req_addr, b_req_wdata} = r;
      end
    end
  end

  logic rst_q;
  always @(posedge clock) rst_q <= reset;

  // Reference model: transaction-level view of grants, memory contents and responses.
  logic [7:0]  ref_mem [MB];
  bit          ref_init = 1'b0;
  exp_t        exp_a[$], exp_b[$];
  int          cyc = 0, busy = 0, acc_cyc = 0;
  bit          last_b = 1'b1, acc_valid = 1'b0;
  req_t        acc;
  logic        acc_oob;
  logic [63:0] held_a_data, held_b_data, held_addr, held_wdata;
  logic        held_a_err, held_b_err;
  int          rsp_a_cnt = 0, mw_count = 0, mr_count = 0;
  logic [63:0] last_a_data, last_b_data;
  logic        last_a_err;
  bit          grant_log[$];

  function automatic logic [63:0] ref_rd(input logic [63:0] addr);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[(int'(addr[5:0]) + i) % MB];
    return v;
  endfunction

  always @(negedge clock) begin
    req_t       r;
    exp_t       e;
    logic [1:0] want;
    bit         win_b;
    logic       oob;
    cyc++;
    if (!ref_init) begin
      for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
      ref_init = 1'b1;
    end
    if (rst_q === 1'b0) begin
      exp_a.delete(); exp_b.delete();
      busy = 0; last_b = 1'b1; acc_valid = 1'b0;
      held_a_data = '0; held_b_data = '0; held_a_err = 1'b0; held_b_err = 1'b0;
      held_addr = '0; held_wdata = '0;
      check_eq("rst_a_rsp_valid", a_rsp_valid, 0);
      check_eq("rst_b_rsp_valid", b_rsp_valid, 0);
      check_eq("rst_a_rsp", {a_rsp_err, a_rsp_data}, 0);
      check_eq("rst_b_rsp", {b_rsp_err, b_rsp_data}, 0);
      check_eq("rst_mem_strobes", {MemWrite, MemRead}, 0);
      check_eq("rst_mem_addr", Memory_Address, 0);
      check_eq("rst_mem_wdata", Write_Data, 0);
    end else if (rst_q === 1'b1) begin
      if (MemWrite === 1'b1) mw_count++;
      if (MemRead === 1'b1) mr_count++;
      if (a_rsp_valid === 1'b1) begin rsp_a_cnt++; last_a_data = a_rsp_data; last_a_err = a_rsp_err; end
      if (b_rsp_valid === 1'b1) last_b_data = b_rsp_data;
      if (acc_valid && acc_cyc == cyc) begin
        check_eq("acc_memwrite", MemWrite, acc.we && !acc_oob);
        check_eq("acc_memread", MemRead, !acc.we && !acc_oob);
        check_eq("acc_addr", Memory_Address, acc.addr);
        check_eq("acc_wdata", Write_Data, acc.wdata);
        held_addr = acc.addr; held_wdata = acc.wdata; acc_valid = 1'b0;
      end else begin
        check_eq("quiet_mem_strobes", {MemWrite, MemRead}, 0);
        check_eq("hold_mem_addr", Memory_Address, held_addr);
        check_eq("hold_mem_wdata", Write_Data, held_wdata);
      end
      if (exp_a.size() > 0 && exp_a[0].due == cyc) begin
        e = exp_a.pop_front();
        check_eq("a_rsp_valid", a_rsp_valid, 1);
        check_eq("a_rsp_data", a_rsp_data, e.data);
        check_eq("a_rsp_err", a_rsp_err, e.err);
        held_a_data = e.data; held_a_err = e.err;
      end else begin
        check_eq("a_rsp_quiet", a_rsp_valid, 0);
        check_eq("a_rsp_hold", {a_rsp_err, a_rsp_data}, {held_a_err, held_a_data});
      end
      if (exp_b.size() > 0 && exp_b[0].due == cyc) begin
        e = exp_b.pop_front();
        check_eq("b_rsp_valid", b_rsp_valid, 1);
        check_eq("b_rsp_data", b_rsp_data, e.data);
        check_eq("b_rsp_err", b_rsp_err, e.err);
        held_b_data = e.data; held_b_err = e.err;
      end else begin
        check_eq("b_rsp_quiet", b_rsp_valid, 0);
        check_eq("b_rsp_hold", {b_rsp_err, b_rsp_data}, {held_b_err, held_b_data});
      end
    end
    if (rst_q !== 1'bx) begin
      if (reset !== 1'b1) begin
        check_eq("rdy_in_reset", {a_req_ready, b_req_ready}, 0);
      end else if (busy > 0) begin
        check_eq("rdy_busy", {a_req_ready, b_req_ready}, 0);
        busy--;
      end else begin
        want = 2'b00;
        if (a_req_valid && b_req_valid) want = last_b ? 2'b10 : 2'b01;
        else if (a_req_valid)           want = 2'b10;
        else if (b_req_valid)           want = 2'b01;
        check_eq("grant", {a_req_ready, b_req_ready}, want);
        if (want != 2'b00) begin
          win_b = (want == 2'b01);
          r = win_b ? {b_req_we, b_req_addr, b_req_wdata} : {a_req_we, a_req_addr, a_req_wdata};
          oob = BOUNDS_EN && (r.addr > 64'(MB - 8));
          e.due  = cyc + 2;
          e.err  = oob;
          e.data = (r.we || oob) ? 64'd0 : ref_rd(r.addr);
          if (r.we && !oob)
            for (int i = 0; i < 8; i++) ref_mem[(int'(r.addr[5:0]) + i) % MB] = r.wdata[8*i +: 8];
          if (win_b) begin exp_b.push_back(e); hs_b_cnt++; end
          else       begin exp_a.push_back(e); hs_a_cnt++; end
          acc = r; acc_oob = oob; acc_cyc = cyc + 1; acc_valid = 1'b1;
          busy = 2; last_b = win_b;
          grant_log.push_back(win_b);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < budget && !idle; k++) begin
      @(posedge clock);
      idle = (ia == qa_req.size()) && (ib == qb_req.size()) && !a_req_valid && !b_req_valid &&
             (exp_a.size() == 0) && (exp_b.size() == 0) && !acc_valid;
    end
    check_eq("idle_reached", idle, 1);
  endtask

  localparam logic [63:0] PAT = 64'h1122334455667788;

  initial begin
    int         g0, mw0, mr0, h0, r0;
    logic [4:0] gbits;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Tie from reset, store/load on a, b loading while a stays busy.
    g0 = grant_log.size(); mw0 = mw_count;
    qa_req.push_back(mk(1'b1, 64'd8, PAT));
    qa_req.push_back(mk(1'b0, 64'd8, 64'd0));
    qa_req.push_back(mk(1'b0, 64'd8, 64'd0));
    qb_req.push_back(mk(1'b0, 64'd8, 64'd0));
    qb_req.push_back(mk(1'b0, 64'd8, 64'd0));
    wait_idle(200);
    gbits = '1;
    for (int k = 0; k < 5; k++) if (g0 + k < grant_log.size()) gbits[4-k] = grant_log[g0+k];
    check_eq("tie_grant_cnt", grant_log.size() - g0, 5);
    check_eq("tie_grant_order", gbits, 5'b01010);
    check_eq("store_memwrite_cycles", mw_count - mw0, 1);
    check_eq("a_load_data", last_a_data, PAT);
    check_eq("b_load_data", last_b_data, PAT);

    // Reset pulse during ACCESS of a store; a load waits across the reset.
    h0 = hs_a_cnt;
    qa_req.push_back(mk(1'b1, 64'd16, 64'hdeadbeefcafef00d));
    for (int k = 0; k < 50 && hs_a_cnt == h0; k++) begin @(negedge clock); #2; end
    check_eq("rst_store_hs", hs_a_cnt - h0, 1);
    r0 = rsp_a_cnt;
    qa_req.push_back(mk(1'b0, 64'd16, 64'd0));
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    wait_idle(200);
    check_eq("rst_only_load_rsp", rsp_a_cnt - r0, 1);

    // Load beyond the last full doubleword.
    mr0 = mr_count;
    qa_req.push_back(mk(1'b0, 64'd60, 64'd0));
    wait_idle(200);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    check_eq("oob_memread_cycles", mr_count - mr0, 0);
    check_eq("oob_err", last_a_err, 1);
    check_eq("oob_data", last_a_data, 0);
`else
    check_eq("nobounds_memread_cycles", mr_count - mr0, 1);
    check_eq("nobounds_err", last_a_err, 0);
`endif

    // Random traffic with occasional one-cycle reset pulses.
    rand_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 79) != 0);
    end
    @(posedge clock); #1;
    reset   = 1'b1;
    rand_en = 1'b0;
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
